// File: rtl/rv32i_types.sv
// Shared types for the branch-prediction training path.
// Pure declarations, no timing or storage.
// No handshakes here; consumers define their own flow control.
package rv32i_types;

    localparam int BR_PRED_IDX_W = 6;

    typedef enum logic {
        BR_NOT_TAKEN = 1'b0,
        BR_TAKEN     = 1'b1
    } br_pred_dir_t;

    typedef struct packed {
        logic [BR_PRED_IDX_W-1:0] idx;
        logic                     pred;
    } br_pred_entry_t;

    // A prediction is wrong when the stored direction disagrees with the resolved one.
    function automatic logic br_pred_miss(input logic pred, input logic taken);
        return pred != taken;
    endfunction

endpackage

// File: rtl/br_pred_fifo.sv
// In-order synchronous FIFO of branch-prediction entries with flush.
// Read data is the head entry, combinational; state updates at the clock edge.
// Push ignored when full, pop ignored when empty; flush clears pointers and drops a same-cycle push.
module br_pred_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  br_pred_entry_t   push_dat,
    input  logic             pop,
    output br_pred_entry_t   pop_dat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    br_pred_entry_t   mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[head_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next pointer/occupancy state; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_push) begin
            tail_d = tail_q + 1'b1;
        end
        if (do_pop) begin
            head_d = head_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is deliberately not reset; a push in a flush cycle is discarded.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[tail_q] <= push_dat;
        end
    end

endmodule

// File: rtl/br_pred_update_queue.sv
// Tracks in-flight predictions and emits counter-table training updates at commit.
// Update/mispredict outputs are registered: they appear 1 cycle after the pop.
// fetch_ready drops when full, commit_ready drops when empty; optional BR_PRED_STATS_EN adds counters.
module br_pred_update_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = BR_PRED_IDX_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   fetch_valid,
    output logic                   fetch_ready,
    input  logic [IDX_W-1:0]       fetch_idx,
    input  logic                   fetch_pred,
    input  logic                   commit_valid,
    output logic                   commit_ready,
    input  logic                   commit_taken,
    output logic                   upd_valid,
    output logic [IDX_W-1:0]       upd_idx,
    output logic                   upd_inc,
    output logic                   upd_dec,
    output logic                   mispredict,
    output logic [$clog2(DEPTH):0] count
`ifdef BR_PRED_STATS_EN
    ,
    output logic [31:0]            stat_commits,
    output logic [31:0]            stat_mispredicts
`endif
);

    // The entry struct is sized by the package width, so the index width must match it.
    if (IDX_W != BR_PRED_IDX_W) begin : g_idx_w_check
        $error("IDX_W must equal rv32i_types::BR_PRED_IDX_W");
    end

    br_pred_entry_t push_entry;
    br_pred_entry_t head_entry;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pop_fire;
    logic           miss;
    br_pred_dir_t   resolved_dir;

    logic             upd_valid_q, upd_valid_d;
    logic [IDX_W-1:0] upd_idx_q,   upd_idx_d;
    logic             upd_inc_q,   upd_inc_d;
    logic             upd_dec_q,   upd_dec_d;
    logic             mispredict_q, mispredict_d;

    assign push_entry   = '{idx: fetch_idx, pred: fetch_pred};
    assign fetch_ready  = ~fifo_full;
    assign commit_ready = ~fifo_empty;
    assign pop_fire     = commit_valid & commit_ready;
    assign resolved_dir = br_pred_dir_t'(commit_taken);
    assign miss         = br_pred_miss(head_entry.pred, commit_taken);

    br_pred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (fetch_valid),
        .push_dat (push_entry),
        .pop      (commit_valid),
        .pop_dat  (head_entry),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (count)
    );

    // Build the training update for the entry popped this cycle; all zero otherwise.
    always_comb begin
        upd_valid_d  = 1'b0;
        upd_idx_d    = '0;
        upd_inc_d    = 1'b0;
        upd_dec_d    = 1'b0;
        mispredict_d = 1'b0;
        if (pop_fire) begin
            upd_valid_d  = 1'b1;
            upd_idx_d    = head_entry.idx;
            upd_inc_d    = (resolved_dir == BR_TAKEN);
            upd_dec_d    = (resolved_dir == BR_NOT_TAKEN);
            mispredict_d = miss;
        end
    end

    // Registered update stage; reset also kills an update popped in the reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid_q  <= 1'b0;
            upd_idx_q    <= '0;
            upd_inc_q    <= 1'b0;
            upd_dec_q    <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            upd_valid_q  <= upd_valid_d;
            upd_idx_q    <= upd_idx_d;
            upd_inc_q    <= upd_inc_d;
            upd_dec_q    <= upd_dec_d;
            mispredict_q <= mispredict_d;
        end
    end

    assign upd_valid  = upd_valid_q;
    assign upd_idx    = upd_idx_q;
    assign upd_inc    = upd_inc_q;
    assign upd_dec    = upd_dec_q;
    assign mispredict = mispredict_q;

`ifdef BR_PRED_STATS_EN
    logic [31:0] stat_commits_q, stat_commits_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    // Lifetime commit/mispredict tallies; flush leaves them alone, they wrap at 2^32.
    always_comb begin
        stat_commits_d     = stat_commits_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (pop_fire) begin
            stat_commits_d = stat_commits_q + 32'd1;
            if (miss) begin
                stat_mispredicts_d = stat_mispredicts_q + 32'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_commits_q     <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_commits_q     <= stat_commits_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_commits     = stat_commits_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_br_pred_update_queue.sv
// Directed, table-driven bench for br_pred_update_queue.
// Each table row is one clock: inputs driven at negedge, outputs checked 1 time unit after posedge.
// Reset, mid-operation reset and the optional statistics are hand-written sequences.
module tb_br_pred_update_queue;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       fetch_valid;
    logic       fetch_ready;
    logic [5:0] fetch_idx;
    logic       fetch_pred;
    logic       commit_valid;
    logic       commit_ready;
    logic       commit_taken;
    logic       upd_valid;
    logic [5:0] upd_idx;
    logic       upd_inc;
    logic       upd_dec;
    logic       mispredict;
    logic [3:0] count;
`ifdef BR_PRED_STATS_EN
    logic [31:0] stat_commits;
    logic [31:0] stat_mispredicts;
`endif

    int checks = 0;
    int errors = 0;

    br_pred_update_queue #(
        .DEPTH (8),
        .IDX_W (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .fetch_idx    (fetch_idx),
        .fetch_pred   (fetch_pred),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_taken (commit_taken),
        .upd_valid    (upd_valid),
        .upd_idx      (upd_idx),
        .upd_inc      (upd_inc),
        .upd_dec      (upd_dec),
        .mispredict   (mispredict),
        .count        (count)
`ifdef BR_PRED_STATS_EN
        ,
        .stat_commits     (stat_commits),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       fv;
        logic [5:0] fidx;
        logic       fpred;
        logic       cv;
        logic       ct;
        logic       fl;
        logic       e_uv;
        logic [5:0] e_idx;
        logic       e_inc;
        logic       e_dec;
        logic       e_mis;
        logic [3:0] e_cnt;
        logic       e_fr;
        logic       e_cr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic fv, input logic [5:0] fidx, input logic fpred,
                                input logic cv, input logic ct, input logic fl,
                                input logic uv, input logic [5:0] idx, input logic inc,
                                input logic dec, input logic mis, input logic [3:0] cnt,
                                input logic fr, input logic cr);
        vec_t v;
        v.fv = fv;  v.fidx = fidx; v.fpred = fpred;
        v.cv = cv;  v.ct = ct;     v.fl = fl;
        v.e_uv = uv; v.e_idx = idx; v.e_inc = inc; v.e_dec = dec; v.e_mis = mis;
        v.e_cnt = cnt; v.e_fr = fr; v.e_cr = cr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [5:0] fidx, input logic fpred,
                         input logic cv, input logic ct, input logic fl);
        @(negedge clk);
        fetch_valid  = fv;
        fetch_idx    = fidx;
        fetch_pred   = fpred;
        commit_valid = cv;
        commit_taken = ct;
        flush        = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input vec_t v, input int n);
        drive(v.fv, v.fidx, v.fpred, v.cv, v.ct, v.fl);
        chk($sformatf("v%0d_upd_valid", n),   32'(upd_valid),    32'(v.e_uv));
        chk($sformatf("v%0d_upd_idx", n),     32'(upd_idx),      32'(v.e_idx));
        chk($sformatf("v%0d_upd_inc", n),     32'(upd_inc),      32'(v.e_inc));
        chk($sformatf("v%0d_upd_dec", n),     32'(upd_dec),      32'(v.e_dec));
        chk($sformatf("v%0d_mispredict", n),  32'(mispredict),   32'(v.e_mis));
        chk($sformatf("v%0d_count", n),       32'(count),        32'(v.e_cnt));
        chk($sformatf("v%0d_fetch_ready", n), 32'(fetch_ready),  32'(v.e_fr));
        chk($sformatf("v%0d_commit_ready", n),32'(commit_ready), 32'(v.e_cr));
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        fetch_valid  = 1'b0;
        fetch_idx    = '0;
        fetch_pred   = 1'b0;
        commit_valid = 1'b0;
        commit_taken = 1'b0;

        // Single push, resolved not-taken against a taken prediction.
        tbl.push_back(mk(1, 6'd5, 1, 0, 0, 0,  0, 6'd0, 0, 0, 0, 4'd1, 1, 1));
        tbl.push_back(mk(0, 6'd0, 0, 1, 0, 0,  1, 6'd5, 0, 1, 1, 4'd0, 1, 0));
        // Commit while empty is ignored.
        tbl.push_back(mk(0, 6'd0, 0, 1, 1, 0,  0, 6'd0, 0, 0, 0, 4'd0, 1, 0));
        // Fill: idx 0..7, pred alternating 0/1.
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 6'(i), (i % 2 == 1), 0, 0, 0,  0, 6'd0, 0, 0, 0, 4'(i + 1), (i != 7), 1));
        // Ninth push while full is rejected.
        tbl.push_back(mk(1, 6'd63, 0, 0, 0, 0,  0, 6'd0, 0, 0, 0, 4'd8, 0, 1));
        // Drain with taken=1: mispredict only where pred was 0 (even idx).
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 6'd0, 0, 1, 1, 0,  1, 6'(i), 1, 0, (i % 2 == 0), 4'(7 - i), 1, (i != 7)));
        // Occupancy 3, then push and pop together.
        tbl.push_back(mk(1, 6'd20, 1, 0, 0, 0,  0, 6'd0, 0, 0, 0, 4'd1, 1, 1));
        tbl.push_back(mk(1, 6'd21, 0, 0, 0, 0,  0, 6'd0, 0, 0, 0, 4'd2, 1, 1));
        tbl.push_back(mk(1, 6'd22, 1, 0, 0, 0,  0, 6'd0, 0, 0, 0, 4'd3, 1, 1));
        tbl.push_back(mk(1, 6'd23, 0, 1, 1, 0,  1, 6'd20, 1, 0, 0, 4'd3, 1, 1));
        tbl.push_back(mk(0, 6'd0, 0, 1, 0, 0,  1, 6'd21, 0, 1, 0, 4'd2, 1, 1));
        tbl.push_back(mk(0, 6'd0, 0, 1, 0, 0,  1, 6'd22, 0, 1, 1, 4'd1, 1, 1));
        tbl.push_back(mk(0, 6'd0, 0, 1, 0, 0,  1, 6'd23, 0, 1, 0, 4'd0, 1, 0));
        // Occupancy 4 headed by idx 9, then flush + commit + push together.
        tbl.push_back(mk(1, 6'd9,  1, 0, 0, 0,  0, 6'd0, 0, 0, 0, 4'd1, 1, 1));
        tbl.push_back(mk(1, 6'd10, 0, 0, 0, 0,  0, 6'd0, 0, 0, 0, 4'd2, 1, 1));
        tbl.push_back(mk(1, 6'd11, 0, 0, 0, 0,  0, 6'd0, 0, 0, 0, 4'd3, 1, 1));
        tbl.push_back(mk(1, 6'd12, 0, 0, 0, 0,  0, 6'd0, 0, 0, 0, 4'd4, 1, 1));
        tbl.push_back(mk(1, 6'd40, 0, 1, 1, 1,  1, 6'd9, 1, 0, 0, 4'd0, 1, 0));
        // Pushed entry is gone: a further commit does nothing.
        tbl.push_back(mk(0, 6'd0, 0, 1, 1, 0,  0, 6'd0, 0, 0, 0, 4'd0, 1, 0));
        // Queue is usable after the flush.
        tbl.push_back(mk(1, 6'd13, 0, 0, 0, 0,  0, 6'd0, 0, 0, 0, 4'd1, 1, 1));
        tbl.push_back(mk(0, 6'd0, 0, 1, 1, 0,  1, 6'd13, 1, 0, 1, 4'd0, 1, 0));

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fetch_ready",  32'(fetch_ready),  32'd1);
        chk("rst_commit_ready", 32'(commit_ready), 32'd0);
        chk("rst_count",        32'(count),        32'd0);
        chk("rst_upd_valid",    32'(upd_valid),    32'd0);
        chk("rst_upd_idx",      32'(upd_idx),      32'd0);
        chk("rst_upd_inc_dec",  32'({upd_inc, upd_dec, mispredict}), 32'd0);
`ifdef BR_PRED_STATS_EN
        chk("rst_stat_commits", stat_commits,     32'd0);
        chk("rst_stat_misp",    stat_mispredicts, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 6'd0, 0, 0, 0, 0);
            chk($sformatf("idle%0d_upd_valid", i), 32'(upd_valid), 32'd0);
        end

        for (int i = 0; i < tbl.size(); i++)
            apply_vec(tbl[i], i);

        // Reset mid-operation kills the update of a pop in the reset cycle.
        drive(1, 6'd30, 1, 0, 0, 0);
        chk("mrst_pre_count", 32'(count), 32'd1);
        @(negedge clk);
        fetch_valid  = 1'b0;
        commit_valid = 1'b1;
        commit_taken = 1'b1;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_upd_valid",    32'(upd_valid),    32'd0);
        chk("mrst_upd_idx",      32'(upd_idx),      32'd0);
        chk("mrst_count",        32'(count),        32'd0);
        chk("mrst_commit_ready", 32'(commit_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 6'd0, 0, 0, 0, 0);
        chk("mrst_after_upd_valid", 32'(upd_valid), 32'd0);

`ifdef BR_PRED_STATS_EN
        // Six commits, two mispredicts (pred=1 resolved not-taken), then flush and reset.
        for (int i = 0; i < 6; i++)
            drive(1, 6'(i), (i < 2), 0, 0, 0);
        for (int i = 0; i < 6; i++)
            drive(0, 6'd0, 0, 1, 0, 0);
        drive(0, 6'd0, 0, 0, 0, 0);
        chk("stat_commits",        stat_commits,     32'd6);
        chk("stat_mispredicts",    stat_mispredicts, 32'd2);
        drive(0, 6'd0, 0, 0, 0, 1);
        chk("stat_commits_flush",  stat_commits,     32'd6);
        chk("stat_misp_flush",     stat_mispredicts, 32'd2);
        @(negedge clk);
        flush = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        chk("stat_commits_rst",    stat_commits,     32'd0);
        chk("stat_misp_rst",       stat_mispredicts, 32'd0);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/br_pred_update_queue.md
Name: br_pred_update_queue

Overview:
- In-order FIFO that tracks in-flight branch predictions from fetch until commit.
- At commit, compares the resolved direction with the stored prediction.
- Drives the training side of the 2-bit counter table: index plus inc/dec pulse. Also drives a mispredict pulse.
- Sits between fetch (writer of predictions) and the commit/ROB stage (resolver). It is the update end of the counter-table interface.

Parameters:
- DEPTH, 8, queue entries; power of two, minimum 2.
- IDX_W, 6, width of the counter-table index.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  discard all queued entries
- fetch_valid  in  1  fetch pushes a prediction this cycle
- fetch_ready  out  1  queue can accept a push
- fetch_idx  in  IDX_W  counter-table index of the predicted branch
- fetch_pred  in  1  predicted direction, 1 = taken
- commit_valid  in  1  oldest branch resolved this cycle
- commit_ready  out  1  queue holds an entry to resolve
- commit_taken  in  1  resolved direction
- upd_valid  out  1  counter update valid
- upd_idx  out  IDX_W  counter index to update
- upd_inc  out  1  increment pulse to the counter
- upd_dec  out  1  decrement pulse to the counter
- mispredict  out  1  resolved direction differed from the prediction
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset:
  - head, tail and count are 0.
  - upd_valid, upd_inc, upd_dec and mispredict are 0; upd_idx is 0.
  - fetch_ready = 1, commit_ready = 0.
- Handshake signals:
  - fetch_ready = (count != DEPTH). Purely combinational from state; no same-cycle pass-through when full.
  - commit_ready = (count != 0). A commit while empty is ignored: no update, no state change.
- Push: fetch_valid & fetch_ready writes {fetch_idx, fetch_pred} at tail; tail wraps modulo DEPTH.
- Pop: commit_valid & commit_ready reads the entry at head; head wraps modulo DEPTH.
- Simultaneous push and pop: count unchanged. This is legal when full, because fetch_ready is 0 when full, so no push occurs then.
- Update outputs are registered, 1-cycle latency after the pop cycle. In the cycle after a pop:
  - upd_valid = 1.
  - upd_idx = stored idx.
  - upd_inc = commit_taken.
  - upd_dec = !commit_taken.
  - mispredict = (stored pred != commit_taken).
- Update outputs are 0 in every cycle not following a pop. upd_inc and upd_dec are never both 1.
- Flush:
  - A pop in the flush cycle is still processed: its update and mispredict appear next cycle.
  - Afterwards head = tail = count = 0.
  - A push in the flush cycle is dropped.
  - Flush takes effect at the clock edge; fetch_ready and commit_ready are not gated combinationally by flush.
- Reset mid-operation: clears the queue and kills any pending registered update, so no update appears in the cycle after reset.
- Entry storage is not reset; only pointers, count and outputs are.
- The mispredict output is advisory; the pipeline decides whether to raise flush.

Optional Feature:
- Macro: BR_PRED_STATS_EN.
- Defined:
  - Adds outputs stat_commits [31:0] and stat_mispredicts [31:0].
  - stat_commits increments on every pop; stat_mispredicts increments on every pop whose pred != commit_taken.
  - Both counters wrap at 2^32, reset to 0 on rst, and are unaffected by flush.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- rv32i_types gains:
  - br_pred_entry_t, a packed struct {logic [IDX_W-1:0] idx; logic pred;}. IDX_W is supplied as a package localparam BR_PRED_IDX_W = 6, and the module parameter defaults to it.
  - br_pred_dir_t enum {BR_NOT_TAKEN, BR_TAKEN}.
- One sub-module: br_pred_fifo, a generic synchronous FIFO of br_pred_entry_t with push/pop/flush, full/empty and count.
- The top module adds the compare logic, the registered update stage and the optional stats.

Test Plan:
- Reset, then idle: fetch_ready=1, commit_ready=0, count=0; upd_valid stays 0 for 10 cycles.
- Push {idx=5, pred=1}, then commit_taken=0: next cycle upd_valid=1, upd_idx=5, upd_dec=1, upd_inc=0, mispredict=1, count=0.
- Push 8 entries (idx 0..7, pred alternating 0/1):
  - fetch_ready=0 and count=8.
  - A 9th push is rejected.
  - Commit all 8 with taken=1: upd_idx sequence 0..7, upd_inc=1 each time, mispredict on idx 0,2,4,6 only.
- With count=3, assert push and commit in the same cycle: count stays 3; the update carries the oldest idx; the pushed entry is the last to pop.
- With count=4, assert flush together with commit (stored idx=9, pred=1, taken=1) and push:
  - Next cycle upd_valid=1, upd_idx=9, upd_inc=1, mispredict=0, count=0.
  - The pushed entry is gone; commit_ready=0.
- With BR_PRED_STATS_EN defined, 6 commits including 2 mispredicts, then flush: stat_commits=6, stat_mispredicts=2, unchanged after flush, 0 after rst.
